// File: rtl/nibble_serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
// Holds the controller state encoding and the slice width.
package nibble_serial_sub_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_sub_if.sv
// Operand/result handshake bundle for nibble_serial_sub.
// The master side supplies operands and consumes results; the slave is the subtractor.
interface nibble_serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, d, b_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, d, b_out, ovf, zero
    );
endinterface

// File: rtl/nibble_serial_sub_sub4_slice.sv
// Combinational 4-bit subtract x - y - bi using borrow lookahead.
// Computed as x + ~y + ~bi; the borrow out is the inverted carry out.
module sub4_slice
    import nibble_serial_sub_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               bi,
    output logic [SLICE_W-1:0] diff,
    output logic               bo
);

    logic [SLICE_W-1:0] g_s;
    logic [SLICE_W-1:0] p_s;
    logic [SLICE_W:0]   c_s;

    // Lookahead carries over x and ~y; every carry depends only on g/p and c0.
    always_comb begin
        g_s    = x & ~y;
        p_s    = x ^ ~y;
        c_s[0] = ~bi;
        c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);
        diff   = p_s ^ c_s[SLICE_W-1:0];
        bo     = ~c_s[SLICE_W];
    end

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle WIDTH-bit subtractor d = a - b - b_in, one nibble per clock, LSB first.
// A borrow register chains the slices; flags are produced when the last slice lands.
module nibble_serial_sub
    import nibble_serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_sub_if.slave   bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam int MSB    = WIDTH - 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               b_out_q, b_out_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [SLICE_W-1:0] slice_x_s;
    logic [SLICE_W-1:0] slice_y_s;
    logic [SLICE_W-1:0] slice_diff_s;
    logic               slice_bo_s;
    logic [WIDTH-1:0]   res_s;

    // Select the operand nibbles addressed by the slice index.
    always_comb begin
        slice_x_s = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
        slice_y_s = b_q[int'(idx_q) * SLICE_W +: SLICE_W];
    end

    sub4_slice u_slice (
        .x    (slice_x_s),
        .y    (slice_y_s),
        .bi   (borrow_q),
        .diff (slice_diff_s),
        .bo   (slice_bo_s)
    );

    // Next-state and datapath update; res_s is d with the current slice merged in.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        res_s    = d_q;
        res_s[int'(idx_q) * SLICE_W +: SLICE_W] = slice_diff_s;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.b_in;
                    idx_d    = '0;
                    d_d      = '0;
                    b_out_d  = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                d_d      = res_s;
                borrow_d = slice_bo_s;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    b_out_d = slice_bo_s;
                    ovf_d   = (a_q[MSB] != b_q[MSB]) && (res_s[MSB] != a_q[MSB]);
                    zero_d  = (res_s == '0);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            d_q         <= '0;
            b_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            borrow_q    <= borrow_d;
            d_q         <= d_d;
            b_out_q     <= b_out_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.b_out     = b_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub (WIDTH=16): arithmetic reference model
// checked every cycle, plus hand-computed literal results for the directed vectors.
module tb_nibble_serial_sub;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;
    localparam int MSB    = WIDTH - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_sub_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: phase 0 = waiting, 1 = busy, 2 = result offered.
    int               m_phase = 0;
    int               m_cyc   = 0;
    logic [WIDTH:0]   m_full;
    logic [WIDTH-1:0] m_d     = '0;
    logic             m_bo    = 1'b0;
    logic             m_ovf   = 1'b0;
    logic             m_zero  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_full = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.b_in};
                    m_d    = m_full[WIDTH-1:0];
                    m_bo   = m_full[WIDTH];
                    m_ovf  = (bus.a[MSB] != bus.b[MSB]) && (m_d[MSB] != bus.a[MSB]);
                    m_zero = (m_d == '0);
                    m_cyc  = 0;
                    m_phase = 1;
                end
                1: begin
                    m_cyc = m_cyc + 1;
                    if (m_cyc == NSLICE) m_phase = 2;
                end
                2: if (bus.out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare the DUT with the model.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("cyc_in_ready",  32'(bus.in_ready),  32'(m_phase == 0));
            check("cyc_out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
                check("cyc_d",     32'(bus.d),     32'(m_d));
                check("cyc_b_out", 32'(bus.b_out), 32'(m_bo));
                check("cyc_ovf",   32'(bus.ovf),   32'(m_ovf));
                check("cyc_zero",  32'(bus.zero),  32'(m_zero));
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input logic [15:0] ed, input logic ebo, input logic eovf,
                          input logic ezero, input bit hold);
        int lat;
        bus.a = a; bus.b = b; bus.b_in = bin; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a = 16'h0000; bus.b = 16'h0000; bus.b_in = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("lit_d",     32'(bus.d),     32'(ed));
        check("lit_b_out", 32'(bus.b_out), 32'(ebo));
        check("lit_ovf",   32'(bus.ovf),   32'(eovf));
        check("lit_zero",  32'(bus.zero),  32'(ezero));
        check("model_d",   32'(m_d),       32'(ed));
        check("model_bo",  32'(m_bo),      32'(ebo));
        if (!hold) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check("hs_out_valid", 32'(bus.out_valid), 32'd0);
            check("hs_in_ready",  32'(bus.in_ready),  32'd1);
        end
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        bin;
        logic [15:0] d;
        logic        bo, ovf, zero;
    } vec_t;

    vec_t vecs[5] = '{
        '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0},
        '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0},
        '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0},
        '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1}
    };

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = 16'h0000; bus.b = 16'h0000;
        bus.b_in = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_d",         32'(bus.d),         32'd0);
        check("rst_flags", 32'({bus.b_out, bus.ovf, bus.zero}), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d,
                   vecs[i].bo, vecs[i].ovf, vecs[i].zero, 1'b0);
        end

        // Backpressure: result held while new operands are offered and ignored.
        run_op(16'h00FF, 16'h0100, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 16'h1111 * 16'(i + 1); bus.b = 16'h0101; bus.b_in = 1'b1;
            tick();
            check("bp_d",        32'(bus.d),        32'h0000FFFE);
            check("bp_b_out",    32'(bus.b_out),    32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);
        repeat (6) tick();
        check("bp_no_ghost", 32'(bus.out_valid), 32'd0);

        // Reset two cycles into RUN abandons the operation.
        bus.a = 16'hABCD; bus.b = 16'h1234; bus.b_in = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_d",         32'(bus.d),         32'd0);
        check("mr_in_ready",  32'(bus.in_ready),  32'd1);
        check("mr_flags", 32'({bus.b_out, bus.ovf, bus.zero}), 32'd0);
        rst = 1'b0;
        repeat (6) tick();
        check("mr_no_pulse", 32'(bus.out_valid), 32'd0);
        run_op(16'hFFFF, 16'h0F0F, 1'b0, 16'hF0F0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-cycle WIDTH-bit subtractor computing d = a - b - b_in, one 4-bit slice per clock, LSB slice first.
- A borrow register chains the slices from cycle to cycle.
- Companion to the team's combinational 4-bit carry-lookahead adder: this is the subtract direction, used in area-constrained datapaths that accept multi-cycle latency.
- Valid/ready handshake on both input and output sides; output flags for unsigned borrow, signed overflow and zero.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived (localparam), number of 4-bit slices.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- b_in  input  1  borrow in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference, modulo 2^WIDTH.
- b_out  output  1  final borrow: 1 iff a < b + b_in (unsigned).
- ovf  output  1  signed overflow: a[MSB]!=b[MSB] and d[MSB]!=a[MSB].
- zero  output  1  d == 0.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, d=0, b_out=0, ovf=0, zero=0. Slice index and borrow register are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b, b_in; borrow_reg<=b_in; idx<=0; go to RUN.
  - Latched operands are held internally; input ports may change afterwards.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, slice idx computes {bo, s[3:0]} = a_k - b_k - borrow_reg, where a_k = a[4*idx+3:4*idx] and b_k likewise.
  - Implementation: a_k + ~b_k + ~borrow_reg with lookahead borrow; bo = ~carry_out.
  - s is written into d[4*idx+3:4*idx]; borrow_reg<=bo; idx<=idx+1.
  - When idx==NSLICE-1: b_out<=bo, ovf and zero computed from the completed result, go to DONE.
- DONE:
  - out_valid=1; d, b_out, ovf and zero are held stable.
  - On an edge with out_ready=1: go to IDLE with out_valid=0 next cycle.
  - No same-cycle re-accept: in_ready is 0 in DONE, so the earliest next accept is one cycle after the output handshake.
- Latency: accept at edge t means out_valid=1 from edge t+NSLICE (4 cycles for WIDTH=16).
  - Throughput: at most one operation per NSLICE+2 cycles with out_ready held high.
- d during RUN: partially updated, not valid. Consumers must qualify with out_valid.
  - At the accept edge, d is cleared to 0.
- WIDTH==4: a single RUN cycle; the same rules apply.
- in_valid in RUN or DONE is ignored; no operand is lost because in_ready=0.
- out_ready asserted outside DONE has no effect.
- rst asserted in any state, including mid-RUN: the next edge restores all reset values and abandons the operation; no out_valid pulse.
- rst has priority over in_valid and out_ready on the same edge.

Decomposition:
- Shared package holds the state enum typedef (IDLE/RUN/DONE) and the SLICE_W=4 constant.
- One natural sub-module: sub4_slice.
  - Combinational 4-bit borrow-lookahead subtract.
  - Inputs x[3:0], y[3:0], bi; outputs diff[3:0], bo.
  - Generate/propagate terms are formed on x and ~y.
- Top level holds the FSM, slice index counter, operand registers, borrow register and flag logic.

Test Plan:
- (WIDTH=16) a=0x1234, b=0x0234, b_in=0 -> d=0x1000, b_out=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
- a=0x0000, b=0x0001, b_in=0 -> d=0xFFFF, b_out=1, ovf=0, zero=0. Borrow must ripple across all 4 slice-cycles.
- a=0x8000, b=0x0001, b_in=0 -> d=0x7FFF, ovf=1, b_out=0; and a=0x7FFF, b=0xFFFF -> d=0x8000, ovf=1, b_out=1.
- a=0x5555, b=0x5554, b_in=1 -> d=0x0000, zero=1, b_out=0, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands.
  - Required: d and flags stable, in_ready=0, new operands ignored.
  - out_ready=1 -> IDLE next cycle.
- Reset mid-op: assert rst 2 cycles into RUN.
  - Required: next cycle out_valid=0, d=0, in_ready=1, no output pulse.
  - A subsequent op a=0xFFFF, b=0x0F0F -> d=0xF0F0 correctly.
